// File: rtl/uart_tx_frame.sv
// UART transmitter: one parallel word per frame, start + LSB-first data +
// optional parity + one stop bit, one clk cycle per bit, gap-free back-to-back.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  ready,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_d;
  logic                  busy_d;
  logic                  accept;
  logic                  load;

  // A new word can be taken while idle or during the stop bit.
  assign ready  = (state_q == IDLE) || (state_q == STOP);
  assign accept = data_valid & ready;

  // State, datapath and line registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      tx_out    <= tx_d;
      busy      <= busy_d;
    end
  end

  // Next state plus the next line/busy values, so the outputs come straight from flops.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end
      STOP: begin
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture word and parity config on the accepting edge; later input changes are ignored.
    if (load) begin
      shift_d   = p_data;
      par_en_d  = par_en;
      par_bit_d = (^p_data) ^ par_typ;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with a scoreboard and a serial RX model.
module tb_uart_tx_frame;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          ready;
  logic          tx_out;
  logic          busy;

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ready      (ready),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          par_en;
    logic          par;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          cur;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            rx_active = 0;
  int            rx_idx = 0;
  int            rx_len = 0;
  int            idle_cnt = 0;
  int            rx_frames = 0;
  int            rx_last_gap = -1;
  int            rx_last_len = 0;
  logic [DW-1:0] rx_data = '0;
  logic [DW-1:0] rx_last_data = '0;
  logic          rx_last_par = 1'bx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RX model: samples the line on falling edges and checks every field against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      rx_active = 0;
      idle_cnt  = 0;
      sb_q.delete();
    end else begin
      chk("busy", 32'(busy), 32'(rx_active || (tx_out === 1'b0)));
      if (!rx_active) begin
        if (tx_out === 1'b0) begin
          chk("spurious_start", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
          end else begin
            cur.data   = '0;
            cur.par_en = 1'b0;
            cur.par    = 1'b0;
          end
          rx_active   = 1;
          rx_idx      = 0;
          rx_len      = 1;
          rx_data     = '0;
          rx_last_gap = idle_cnt;
        end else begin
          idle_cnt++;
        end
      end else begin
        rx_len++;
        if (rx_idx < int'(DW)) begin
          rx_data[rx_idx] = tx_out;
          chk("data_bit", 32'(tx_out), 32'(cur.data[rx_idx]));
          rx_idx++;
        end else if (cur.par_en && rx_idx == int'(DW)) begin
          rx_last_par = tx_out;
          chk("parity_bit", 32'(tx_out), 32'(cur.par));
          rx_idx++;
        end else begin
          chk("stop_bit", 32'(tx_out), 32'd1);
          rx_active    = 0;
          rx_last_data = rx_data;
          rx_last_len  = rx_len;
          rx_frames++;
          idle_cnt     = 0;
        end
      end
    end
  end

  // Present a word until accepted; the expected frame is queued on the accepting cycle.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    exp_t e;
    bit   done;
    done = 0;
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ready === 1'b1) begin
        e.data   = d;
        e.par_en = pe;
        e.par    = (^d) ^ pt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      data_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Wait for the line to go idle with nothing outstanding, bounded.
  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!rx_active && busy === 1'b0 && sb_q.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst        = 1'b0;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #12;
    chk("reset_tx", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);

    // Reset in the middle of the data bits aborts the frame.
    send(8'hA5, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_out), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("post_reset_ready", 32'(ready), 32'd1);
    chk("post_reset_frames", 32'(rx_frames), 32'd0);

    // Plain 8N1 frame.
    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
    chk("a5_data", 32'(rx_last_data), 32'h0000_00A5);
    chk("a5_len", 32'(rx_last_len), 32'd10);

    // Even then odd parity on the same word.
    send(8'h03, 1'b1, 1'b0);
    wait_idle();
    chk("even_par", 32'(rx_last_par), 32'd0);
    chk("even_len", 32'(rx_last_len), 32'd11);
    send(8'h03, 1'b1, 1'b1);
    wait_idle();
    chk("odd_par", 32'(rx_last_par), 32'd1);
    chk("odd_len", 32'(rx_last_len), 32'd11);

    // Back-to-back frames: second start directly follows the stop bit.
    send(8'h55, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    wait_idle();
    chk("b2b_gap", 32'(rx_last_gap), 32'd0);
    chk("b2b_data", 32'(rx_last_data), 32'h0000_00FF);

    // Valid pulsed while busy is ignored.
    send(8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("ready_in_data", 32'(ready), 32'd0);
    p_data     = 8'h00;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();
    chk("ignored_data", 32'(rx_last_data), 32'h0000_003C);
    repeat (5) @(negedge clk);
    chk("idle_tx", 32'(tx_out), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Inputs change right after acceptance; the latched values are sent.
    send(8'hC6, 1'b1, 1'b1);
    p_data  = 8'h39;
    par_en  = 1'b0;
    par_typ = 1'b0;
    wait_idle();
    chk("latched_data", 32'(rx_last_data), 32'h0000_00C6);
    chk("latched_len", 32'(rx_last_len), 32'd11);
    chk("latched_par", 32'(rx_last_par), 32'd1);

    chk("frame_count", 32'(rx_frames), 32'd7);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
